fifo_side_ctrl: RTL

- Complete one-side pointer and flag controller for the dual-clock FIFO: a parametrised successor to the plain pointer counter.
- Holds the local binary and Gray pointer and synchronises the other domain's Gray pointer internally. Produces the full or empty flag, an almost flag, a fill level and an overflow/underflow error pulse.
- One instance is placed in the write domain (MODE=1) and one in the read domain (MODE=0). Each Gray pointer output is cross-wired to the other instance's remote_gray input.

---
 rtl/fifo_side_ctrl.sv | 111 +++++++++++
 1 files changed

// File: rtl/fifo_side_ctrl.sv
// One side of a dual-clock FIFO: local binary/Gray pointer, remote Gray pointer
// synchroniser, and registered full/empty, almost-flag, level and error outputs.
module fifo_side_ctrl #(
    parameter int ADDRSIZE    = 4,
    parameter int MODE        = 1,
    parameter int SYNC_STAGES = 2,
    parameter int ALMOST_TH   = 2
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                req,
    input  logic [ADDRSIZE:0]   remote_gray,
    output logic [ADDRSIZE-1:0] addr,
    output logic [ADDRSIZE:0]   gray_ptr,
    output logic                flag,
    output logic                almost,
    output logic [ADDRSIZE:0]   level,
    output logic                accept,
    output logic                err
);

    localparam int   PW       = ADDRSIZE + 1;
    localparam logic RST_FLAG = (MODE == 0);

    // Handshake: a request is taken in any cycle where accept = req & ~flag is
    // high; accept is combinational and qualifies the RAM access that cycle.
    // A request while flag is high is dropped and reported on err next cycle.

    logic [PW-1:0] r_bin;
    logic [PW-1:0] r_gray;
    logic [PW-1:0] r_level;
    logic          r_flag;
    logic          r_almost;
    logic          r_err;
    logic [PW-1:0] r_sync [SYNC_STAGES];

    logic          w_inc;
    logic [PW-1:0] w_bin_next;
    logic [PW-1:0] w_gray_next;
    logic [PW-1:0] w_rs_gray;
    logic [PW-1:0] w_rs_bin;
    logic [PW-1:0] w_lvl_next;
    logic          w_flag_next;
    logic          w_almost_next;
    logic          w_err_next;

    assign w_inc       = req & ~r_flag;
    assign w_bin_next  = r_bin + PW'(w_inc);
    assign w_gray_next = w_bin_next ^ (w_bin_next >> 1);
    assign w_err_next  = req & r_flag;

    assign w_rs_gray = r_sync[SYNC_STAGES-1];

    // Each binary bit is the XOR of all Gray bits at or above it.
    for (genvar i = 0; i < PW; i++) begin : g_g2b
        assign w_rs_bin[i] = ^w_rs_gray[PW-1:i];
    end

    if (MODE != 0) begin : g_write_side
        localparam logic [PW-1:0] ALMOST_LVL = PW'((1 << ADDRSIZE) - ALMOST_TH);
        // Full: same address, opposite wrap bit, which in Gray flips the top two bits.
        assign w_flag_next   = (w_gray_next == {~w_rs_gray[PW-1:PW-2], w_rs_gray[PW-3:0]});
        assign w_lvl_next    = w_bin_next - w_rs_bin;
        assign w_almost_next = (w_lvl_next >= ALMOST_LVL);
    end else begin : g_read_side
        localparam logic [PW-1:0] ALMOST_LVL = PW'(ALMOST_TH);
        assign w_flag_next   = (w_gray_next == w_rs_gray);
        assign w_lvl_next    = w_rs_bin - w_bin_next;
        assign w_almost_next = (w_lvl_next <= ALMOST_LVL);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_sync[i] <= '0;
            end
        end else begin
            r_sync[0] <= remote_gray;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_bin    <= '0;
            r_gray   <= '0;
            r_level  <= '0;
            r_flag   <= RST_FLAG;
            r_almost <= RST_FLAG;
            r_err    <= 1'b0;
        end else begin
            r_bin    <= w_bin_next;
            r_gray   <= w_gray_next;
            r_level  <= w_lvl_next;
            r_flag   <= w_flag_next;
            r_almost <= w_almost_next;
            r_err    <= w_err_next;
        end
    end

    assign addr     = r_bin[ADDRSIZE-1:0];
    assign gray_ptr = r_gray;
    assign flag     = r_flag;
    assign almost   = r_almost;
    assign level    = r_level;
    assign accept   = w_inc;
    assign err      = r_err;

endmodule
